host_pcr_master: RTL and testbench
==================================

HOST_PCR_MASTER -- requirements
Module: host_pcr_master

Interface
REQ-001 Parameter ADDR_W, default 5, PCR address width.
REQ-002 Parameter DATA_W, default 64, PCR data width.
REQ-003 Parameter TIMEOUT, default 255, maximum WAIT cycles before error; legal range 1..255.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous active-low reset; asserted when 0, released synchronously to clk by the integrator.
REQ-006 io_cmd_valid  input  1  host command present.
REQ-007 io_cmd_ready  output  1  block accepts a command.
REQ-008 io_cmd_rw  input  1  1 = write, 0 = read.
REQ-009 io_cmd_addr  input  ADDR_W  target PCR address.
REQ-010 io_cmd_data  input  DATA_W  write data; ignored for reads.
REQ-011 io_pcr_req_valid  output  1  request to the PCR file.
REQ-012 io_pcr_req_ready  input  1  PCR file accepts the request.
REQ-013 io_pcr_req_rw, io_pcr_req_addr, io_pcr_req_data  output  1/ADDR_W/DATA_W  latched command fields.
REQ-014 io_pcr_resp_valid  input  1  one-cycle PCR response strobe.
REQ-015 io_pcr_resp_data  input  DATA_W  read data; on writes the PCR file returns the previous value.
REQ-016 io_rsp_valid  output  1  response to host present.
REQ-017 io_rsp_ready  input  1  host accepts the response.
REQ-018 io_rsp_data  output  DATA_W  captured response data.
REQ-019 io_rsp_err  output  1  1 = transaction timed out.
REQ-020 io_busy  output  1  high in every state except IDLE.

Function
REQ-021 The block SHALL implement states IDLE, REQ, WAIT, RESP, one transaction at a time.
REQ-022 IDLE: io_cmd_ready=1; on io_cmd_valid&&io_cmd_ready the block SHALL latch rw/addr/data and enter REQ next cycle.
REQ-023 REQ: io_pcr_req_valid=1 with latched fields held stable; on io_pcr_req_ready enter WAIT next cycle, wait counter cleared to 0.
REQ-024 WAIT: on io_pcr_resp_valid the block SHALL capture io_pcr_resp_data into io_rsp_data, clear io_rsp_err, enter RESP.
REQ-025 WAIT without response: counter increments; when counter==TIMEOUT-1 and no response, the block SHALL set io_rsp_err=1, io_rsp_data=0, enter RESP (exactly TIMEOUT cycles in WAIT).
REQ-026 Response and timeout in the same cycle: response wins, io_rsp_err=0.
REQ-027 RESP: io_rsp_valid=1, data/err stable; on io_rsp_ready return to IDLE next cycle.
REQ-028 io_cmd_ready SHALL be 0 outside IDLE; no command is accepted in the RESP->IDLE cycle.
REQ-029 io_pcr_resp_valid outside WAIT SHALL be ignored with no state change.
REQ-030 Minimum latency: command accepted cycle t, req_valid at t+1; with req_ready at t+1 and resp_valid at t+2, io_rsp_valid at t+3.
REQ-031 Writes and reads follow identical state sequences; only io_pcr_req_rw differs.
REQ-032 io_pcr_req_* and io_rsp_* values SHALL change only on state entry, never while their valid is high.

Reset
REQ-033 While reset=0 the block SHALL be in IDLE; io_cmd_ready=1 (after release), io_pcr_req_valid=0, io_rsp_valid=0, io_rsp_err=0, io_rsp_data=0, io_busy=0, counter=0, latched fields=0.
REQ-034 Reset assertion mid-transaction SHALL abort it immediately (asynchronously) with no response issued.

Verification
REQ-035 Read: cmd rw=0 addr=5'h03; req_ready immediate; resp data 64'hDEAD_BEEF_0000_0001 at t+2 -> rsp_valid at t+3, data matches, err=0.
REQ-036 Write: cmd rw=1 addr=5'h1F data=64'hA5; req_ready delayed 3 cycles -> req fields stable throughout, rsp_valid after response, err=0.
REQ-037 Timeout: TIMEOUT=4, no resp -> exactly 4 WAIT cycles, then rsp_valid=1, err=1, data=0.
REQ-038 Race: resp_valid on the TIMEOUT-th WAIT cycle -> err=0, data captured.
REQ-039 Backpressure: rsp_ready low 5 cycles, cmd_valid held high -> cmd_ready=0, rsp stable, one new command accepted only after return to IDLE.
REQ-040 Reset mid-WAIT: reset=0 -> outputs at REQ-033 values same cycle; stray resp_valid after release ignored.

Source files
------------

// File: rtl/host_pcr_master_if.sv
// Host command / PCR request / host response bundle for host_pcr_master.
// The master modport is the block's view; slave is the environment (host + PCR file).
interface host_pcr_master_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
);
  logic              io_cmd_valid;
  logic              io_cmd_ready;
  logic              io_cmd_rw;
  logic [ADDR_W-1:0] io_cmd_addr;
  logic [DATA_W-1:0] io_cmd_data;

  logic              io_pcr_req_valid;
  logic              io_pcr_req_ready;
  logic              io_pcr_req_rw;
  logic [ADDR_W-1:0] io_pcr_req_addr;
  logic [DATA_W-1:0] io_pcr_req_data;
  logic              io_pcr_resp_valid;
  logic [DATA_W-1:0] io_pcr_resp_data;

  logic              io_rsp_valid;
  logic              io_rsp_ready;
  logic [DATA_W-1:0] io_rsp_data;
  logic              io_rsp_err;
  logic              io_busy;

  modport master (
    input  io_cmd_valid, io_cmd_rw, io_cmd_addr, io_cmd_data,
    output io_cmd_ready,
    output io_pcr_req_valid, io_pcr_req_rw, io_pcr_req_addr, io_pcr_req_data,
    input  io_pcr_req_ready, io_pcr_resp_valid, io_pcr_resp_data,
    output io_rsp_valid, io_rsp_data, io_rsp_err, io_busy,
    input  io_rsp_ready
  );

  modport slave (
    output io_cmd_valid, io_cmd_rw, io_cmd_addr, io_cmd_data,
    input  io_cmd_ready,
    input  io_pcr_req_valid, io_pcr_req_rw, io_pcr_req_addr, io_pcr_req_data,
    output io_pcr_req_ready, io_pcr_resp_valid, io_pcr_resp_data,
    input  io_rsp_valid, io_rsp_data, io_rsp_err, io_busy,
    output io_rsp_ready
  );
endinterface

// File: rtl/host_pcr_master.sv
// Single-outstanding host-to-PCR-file bridge: IDLE -> REQ -> WAIT -> RESP,
// with a bounded wait that turns a missing PCR response into an error response.
module host_pcr_master #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  host_pcr_master_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam int              CNT_W      = 8;
  localparam logic [CNT_W-1:0] W_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [DATA_W-1:0] r_rsp_data;
  logic [DATA_W-1:0] w_rsp_data_next;
  logic              r_rsp_err;
  logic              w_rsp_err_next;
  logic              w_cmd_fire;

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_rsp_data_next = r_rsp_data;
    w_rsp_err_next  = r_rsp_err;
    w_cmd_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.io_cmd_valid) begin
          w_cmd_fire   = 1'b1;
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.io_pcr_req_ready) begin
          w_cnt_next   = '0;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response arriving on the last allowed cycle beats the timeout.
        if (bus.io_pcr_resp_valid) begin
          w_rsp_data_next = bus.io_pcr_resp_data;
          w_rsp_err_next  = 1'b0;
          w_state_next    = S_RESP;
        end else if (r_cnt == W_CNT_LAST) begin
          w_rsp_data_next = '0;
          w_rsp_err_next  = 1'b1;
          w_state_next    = S_RESP;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.io_rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_rsp_data <= w_rsp_data_next;
      r_rsp_err  <= w_rsp_err_next;
      if (w_cmd_fire) begin
        r_rw   <= bus.io_cmd_rw;
        r_addr <= bus.io_cmd_addr;
        r_data <= bus.io_cmd_data;
      end
    end
  end

  assign bus.io_cmd_ready     = (r_state == S_IDLE);
  assign bus.io_pcr_req_valid = (r_state == S_REQ);
  assign bus.io_pcr_req_rw    = r_rw;
  assign bus.io_pcr_req_addr  = r_addr;
  assign bus.io_pcr_req_data  = r_data;
  assign bus.io_rsp_valid     = (r_state == S_RESP);
  assign bus.io_rsp_data      = r_rsp_data;
  assign bus.io_rsp_err       = r_rsp_err;
  assign bus.io_busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_host_pcr_master.sv
// Randomized bench for host_pcr_master: a cycle-accurate expectation is derived
// from per-transaction delays (request accept, response slot, host accept).
module tb_host_pcr_master;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int T  = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   n_txn;
  logic [DW-1:0] mem [32];

  host_pcr_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  host_pcr_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    bus.io_cmd_valid      = 1'b0;
    bus.io_cmd_rw         = 1'b0;
    bus.io_cmd_addr       = '0;
    bus.io_cmd_data       = '0;
    bus.io_pcr_req_ready  = 1'b0;
    bus.io_pcr_resp_valid = 1'b0;
    bus.io_pcr_resp_data  = '0;
    bus.io_rsp_ready      = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},      64'(bus.io_busy), 64'd0);
    chk({tag, "_req_valid"}, 64'(bus.io_pcr_req_valid), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.io_rsp_valid), 64'd0);
    chk({tag, "_rsp_err"},   64'(bus.io_rsp_err), 64'd0);
    chk({tag, "_rsp_data"},  bus.io_rsp_data, 64'd0);
    chk({tag, "_req_rw"},    64'(bus.io_pcr_req_rw), 64'd0);
    chk({tag, "_req_addr"},  64'(bus.io_pcr_req_addr), 64'd0);
    chk({tag, "_req_data"},  bus.io_pcr_req_data, 64'd0);
  endtask

  // Entry/exit: just after a rising edge. k = WAIT cycle index of the PCR
  // response; k >= T means the PCR file never answers.
  task automatic run_txn(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int d_req, input int k, input int d_rsp, input bit hold);
    int            rsp_cyc;
    int            last_req;
    logic [DW-1:0] payload;
    logic [DW-1:0] exp_data;
    logic          exp_err;
    payload  = mem[addr];
    exp_err  = (k >= T);
    exp_data = exp_err ? '0 : payload;
    last_req = 1 + d_req;
    rsp_cyc  = 3 + d_req + ((k < T) ? k : T - 1);

    bus.io_cmd_valid      = 1'b1;
    bus.io_cmd_rw         = rw;
    bus.io_cmd_addr       = addr;
    bus.io_cmd_data       = data;
    bus.io_pcr_req_ready  = 1'b0;
    bus.io_pcr_resp_valid = 1'b0;
    bus.io_rsp_ready      = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 64'(bus.io_cmd_ready), 64'd1);
    chk("idle_busy", 64'(bus.io_busy), 64'd0);

    for (int cyc = 1; cyc <= rsp_cyc + d_rsp; cyc++) begin
      @(posedge clk);
      #1;
      if (hold) begin
        bus.io_cmd_valid = 1'b1;
        bus.io_cmd_rw    = 1'($urandom);
        bus.io_cmd_addr  = AW'($urandom);
        bus.io_cmd_data  = {$urandom, $urandom};
      end else begin
        bus.io_cmd_valid = 1'b0;
      end
      if (cyc < last_req) bus.io_pcr_req_ready = 1'b0;
      else if (cyc == last_req) bus.io_pcr_req_ready = 1'b1;
      else bus.io_pcr_req_ready = 1'($urandom);
      if (cyc == last_req && rw) mem[addr] = data;
      if (cyc < rsp_cyc && cyc > last_req) begin
        bus.io_pcr_resp_valid = (cyc == 2 + d_req + k);
        bus.io_pcr_resp_data  = (cyc == 2 + d_req + k) ? payload : {$urandom, $urandom};
      end else begin
        bus.io_pcr_resp_valid = 1'($urandom);
        bus.io_pcr_resp_data  = {$urandom, $urandom};
      end
      bus.io_rsp_ready = (cyc < rsp_cyc) ? 1'($urandom) : (cyc == rsp_cyc + d_rsp);
      @(negedge clk);
      chk("busy", 64'(bus.io_busy), 64'd1);
      chk("cmd_ready", 64'(bus.io_cmd_ready), 64'd0);
      chk("req_valid", 64'(bus.io_pcr_req_valid), 64'(cyc <= last_req));
      chk("rsp_valid", 64'(bus.io_rsp_valid), 64'(cyc >= rsp_cyc));
      if (cyc <= last_req) begin
        chk("req_rw",   64'(bus.io_pcr_req_rw), 64'(rw));
        chk("req_addr", 64'(bus.io_pcr_req_addr), 64'(addr));
        chk("req_data", bus.io_pcr_req_data, data);
      end
      if (cyc >= rsp_cyc) begin
        chk("rsp_data", bus.io_rsp_data, exp_data);
        chk("rsp_err",  64'(bus.io_rsp_err), 64'(exp_err));
      end
    end
    @(posedge clk);
    #1;
    bus.io_rsp_ready      = 1'b0;
    bus.io_pcr_resp_valid = 1'b0;
    bus.io_pcr_req_ready  = 1'b0;
    n_txn++;
    $display("txn %0d rw=%0d addr=%h d_req=%0d k=%0d d_rsp=%0d hold=%0d exp_err=%0d exp_data=%h",
             n_txn, rw, addr, d_req, k, d_rsp, hold, exp_err, exp_data);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_txn    = 0;
    for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
    mem[3] = 64'hDEAD_BEEF_0000_0001;
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", 64'(bus.io_cmd_ready), 64'd1);
    @(posedge clk);
    #1;

    run_txn(1'b0, 5'h03, 64'h0, 0, 0, 0, 1'b0);         // minimum-latency read
    run_txn(1'b1, 5'h1F, 64'hA5, 3, 1, 0, 1'b0);        // delayed req_ready write
    run_txn(1'b0, 5'h07, 64'h0, 0, T, 0, 1'b0);         // timeout
    run_txn(1'b1, 5'h03, 64'h1234, 1, T - 1, 1, 1'b0);  // response on the last WAIT cycle
    run_txn(1'b0, 5'h1F, 64'h0, 0, 2, 5, 1'b1);         // host backpressure, cmd held
    run_txn(1'b0, 5'h1F, 64'h0, 0, 0, 0, 1'b0);         // read back the earlier write

    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), AW'($urandom), {$urandom, $urandom},
              $urandom_range(0, 4), $urandom_range(0, T + 1), $urandom_range(0, 4),
              1'($urandom));
    end

    bus.io_cmd_valid = 1'b0;
    @(negedge clk);
    chk("end_busy", 64'(bus.io_busy), 64'd0);
    chk("end_cmd_ready", 64'(bus.io_cmd_ready), 64'd1);
    chk("end_rsp_valid", 64'(bus.io_rsp_valid), 64'd0);

    // Abort a transaction in WAIT with an asynchronous reset.
    @(posedge clk);
    #1;
    bus.io_cmd_valid = 1'b1;
    bus.io_cmd_rw    = 1'b1;
    bus.io_cmd_addr  = 5'h15;
    bus.io_cmd_data  = 64'hFFFF_0000_FFFF_0000;
    @(posedge clk);
    #1;
    bus.io_cmd_valid     = 1'b0;
    bus.io_pcr_req_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.io_pcr_req_ready = 1'b0;
    @(posedge clk);
    #2;
    chk("prereset_busy", 64'(bus.io_busy), 64'd1);
    reset = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.io_pcr_resp_valid = 1'b1;
    bus.io_pcr_resp_data  = {$urandom, $urandom};
    @(negedge clk);
    chk("stray_busy", 64'(bus.io_busy), 64'd0);
    chk("stray_rsp_valid", 64'(bus.io_rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    bus.io_pcr_resp_valid = 1'b0;
    @(negedge clk);
    chk("post_busy", 64'(bus.io_busy), 64'd0);
    chk("post_rsp_valid", 64'(bus.io_rsp_valid), 64'd0);
    chk("post_rsp_data", bus.io_rsp_data, 64'd0);
    chk("post_cmd_ready", 64'(bus.io_cmd_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
